// File: rtl/counter_monitor_if.sv
// -----------------------------------------------------------------------------
// counter_monitor_if
// Groups the signals between a modulo-2^WIDTH up-counter checker and its
// environment.
//   master : drives enable/clear/counterValue, observes the health outputs
//   slave  : the monitor itself
// Signals:
//   enable       - enable shared with the monitored counter
//   clear        - synchronous clear of counts and FSM
//   counterValue - count output of the monitored counter
//   locked       - FSM is tracking the count stream
//   wrapPulse    - one-cycle pulse per legal wrap 2^WIDTH-1 -> 0
//   wrapCount    - saturating count of legal wraps
//   errorFlag    - sticky mismatch flag
//   errorCount   - saturating count of mismatches
//   fault        - FSM has given up after too many mismatches
// -----------------------------------------------------------------------------
interface counter_monitor_if #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
);
    logic              enable;
    logic              clear;
    logic [WIDTH-1:0]  counterValue;
    logic              locked;
    logic              wrapPulse;
    logic [WRAP_W-1:0] wrapCount;
    logic              errorFlag;
    logic [ERR_W-1:0]  errorCount;
    logic              fault;

    modport master (
        output enable, clear, counterValue,
        input  locked, wrapPulse, wrapCount, errorFlag, errorCount, fault
    );

    modport slave (
        input  enable, clear, counterValue,
        output locked, wrapPulse, wrapCount, errorFlag, errorCount, fault
    );
endinterface

// File: rtl/counter_monitor.sv
// -----------------------------------------------------------------------------
// counter_monitor
// Checks every step of a free-running modulo-2^WIDTH up-counter with enable.
// Each edge in TRACK compares the sampled count with the previous sample plus
// the previous enable, then resyncs to the current sample. Legal wraps are
// pulsed and counted; mismatches set a sticky flag and are counted, and
// reaching ERR_LIMIT mismatches parks the FSM in FAULT until clear or reset.
// Ports:
//   clock - rising-edge clock shared with the counter
//   reset - asynchronous active-high reset, clears all state
//   bus   - counter_monitor_if slave modport (inputs enable/clear/counterValue,
//           registered health outputs)
// -----------------------------------------------------------------------------
module counter_monitor #(
    parameter int WIDTH     = 3,
    parameter int WRAP_W    = 8,
    parameter int ERR_W     = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clock,
    input  logic             reset,
    counter_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e            state_q,       state_d;
    logic [WIDTH-1:0]  prev_value_q,  prev_value_d;
    logic              prev_enable_q, prev_enable_d;
    logic [WRAP_W-1:0] wrap_count_q,  wrap_count_d;
    logic [ERR_W-1:0]  err_count_q,   err_count_d;
    logic              err_flag_q,    err_flag_d;
    logic              wrap_pulse_q,  wrap_pulse_d;

    logic [WIDTH-1:0]  expected;
    logic              mismatch;
    logic              legal_wrap;

    // Carry out of the top bit is dropped, which is what makes 2^WIDTH-1 -> 0
    // an expected step rather than a mismatch.
    assign expected   = prev_value_q + WIDTH'(prev_enable_q);
    assign mismatch   = (bus.counterValue != expected);
    assign legal_wrap = prev_enable_q && (prev_value_q == '1) && (bus.counterValue == '0);

    // NOTE: every signal gets its default before the case so no path through
    // this block leaves a value unassigned; that is what keeps it free of latches.
    always_comb begin
        state_d       = state_q;
        prev_value_d  = bus.counterValue;
        prev_enable_d = bus.enable;
        wrap_count_d  = wrap_count_q;
        err_count_d   = err_count_q;
        err_flag_d    = err_flag_q;
        wrap_pulse_d  = 1'b0;

        if (bus.clear) begin
            // Clear outranks any comparison made on the same edge.
            state_d      = ST_SYNC;
            wrap_count_d = '0;
            err_count_d  = '0;
            err_flag_d   = 1'b0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (mismatch) begin
                        err_flag_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        if (err_count_d == ERR_W'(ERR_LIMIT)) begin
                            state_d = ST_FAULT;
                        end
                    end else if (legal_wrap) begin
                        wrap_pulse_d = 1'b1;
                        if (wrap_count_q != '1) begin
                            wrap_count_d = wrap_count_q + WRAP_W'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    // Counts and flag hold; only clear or reset leaves FAULT.
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_SYNC;
            prev_value_q  <= '0;
            prev_enable_q <= 1'b0;
            wrap_count_q  <= '0;
            err_count_q   <= '0;
            err_flag_q    <= 1'b0;
            wrap_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_value_q  <= prev_value_d;
            prev_enable_q <= prev_enable_d;
            wrap_count_q  <= wrap_count_d;
            err_count_q   <= err_count_d;
            err_flag_q    <= err_flag_d;
            wrap_pulse_q  <= wrap_pulse_d;
        end
    end

    // Status decoded purely from registers: no combinational input-to-output path.
    assign bus.locked     = (state_q == ST_TRACK);
    assign bus.fault      = (state_q == ST_FAULT);
    assign bus.wrapPulse  = wrap_pulse_q;
    assign bus.wrapCount  = wrap_count_q;
    assign bus.errorFlag  = err_flag_q;
    assign bus.errorCount = err_count_q;

endmodule
